rhd_frame_packer: RTL and testbench
===================================

// Module: rhd_frame_packer
// PURPOSE
//  Downstream of the RHD2000 acquisition sequencer. On each completed scan it captures the
//  32-channel x 16-bit sample frame and serialises it into a framed 16-bit word stream for
//  the host link. Each frame carries a sync word, a 32-bit frame counter and an XOR checksum.
//  The output uses valid/ready backpressure. Frames that arrive while a frame is still
//  draining are dropped and counted.
// PARAMETERS
//  CHANNELS   32        sample words per frame
//  SAMPLE_W   16        bits per sample and per stream word
//  MAGIC      16'hC691  sync/header word
// PORTS
//  clk             in   1                   system clock, rising edge
//  rst             in   1                   asynchronous reset, active-high
//  enable          in   1                   1 = accept new frames; 0 = ignore frame_valid (no drop count)
//  frame_in        in   CHANNELS*SAMPLE_W   channel i = frame_in[i*SAMPLE_W +: SAMPLE_W]
//  frame_valid     in   1                   1-cycle pulse: frame_in is complete and stable this cycle
//  m_data          out  SAMPLE_W            stream word
//  m_valid         out  1                   m_data valid
//  m_ready         in   1                   sink accepts; a beat transfers when m_valid & m_ready
//  m_last          out  1                   high on the checksum word (final beat of the frame)
//  busy            out  1                   high in any state other than IDLE
//  frame_count     out  32                  frames captured since reset
//  drop_count      out  16                  frames dropped; saturates at 16'hFFFF
//  overflow        out  1                   sticky; set on any drop
//  clear_overflow  in   1                   clears overflow and drop_count
// BEHAVIOUR
//  Reset (async, rst=1): every output is 0, state = IDLE, shadow frame cleared, running XOR cleared.
//   rst asserted mid-frame abandons the frame; m_valid falls without waiting for a clock edge.
//  Frame layout, 36 words, in this order:
//   MAGIC, cnt[31:16], cnt[15:0], ch0 .. ch31, checksum.
//   cnt is the frame_count value after the capture increment; the first frame carries cnt=1.
//   checksum = XOR of the 35 preceding words.
//  States:
//   IDLE  -> HDR on frame_valid & enable. Same edge: latch frame_in into the shadow register,
//            frame_count += 1 (wraps at 2^32), snapshot cnt.
//   HDR -> CNTH -> CNTL -> SMP -> CSUM: each transition occurs only on an accepted beat.
//            SMP holds a 5-bit index running 0..31 and leaves on the beat with index 31.
//   CSUM  -> IDLE on an accepted beat.
//  Latency: frame_valid on edge N gives m_valid=1 with m_data=MAGIC after edge N.
//  With m_ready tied high, 36 cycles per frame.
//  Outputs are registered. While m_valid & !m_ready, m_data, m_valid and m_last hold stable.
//  m_valid stays high from HDR through CSUM. There are no gaps inside a frame.
//  Running XOR: cleared on capture; on each accepted beat before CSUM, XOR in that word.
//   m_data in CSUM = running XOR.
//  Drop: frame_valid & enable while busy, except on the final-beat edge defined below, causes
//   drop_count += 1 (saturating) and overflow = 1. The shadow register and the stream are untouched.
//  Final-beat edge (CSUM & m_valid & m_ready) coinciding with frame_valid & enable:
//   the new frame is captured, state goes straight to HDR and no drop is recorded.
//   Back-to-back frames therefore have zero idle cycles.
//  clear_overflow coinciding with a drop: the drop wins (overflow=1, drop_count=1).
//  enable deasserted mid-frame: the current frame completes normally.
//  The shadow register decouples frame_in, so upstream may change frame_in after frame_valid.
// TESTING
//  1) m_ready=1; frame_in ch i = 16'h0100+i; one frame_valid pulse.
//     -> 36 beats: C691, 0000, 0001, 0100..011F, then the XOR checksum; m_last on beat 36 only;
//        busy drops 1 cycle after the last beat.
//  2) As test 1, but m_ready toggles pseudo-randomly with 30% high.
//     -> identical word sequence; m_data stable under stall; count of accepted beats = 36.
//  3) Second frame_valid at beat 10 of frame 1.
//     -> frame 1 is unaffected; drop_count=1; overflow=1; frame_count=1.
//     Then clear_overflow -> overflow=0, drop_count=0.
//  4) frame_valid exactly on the final-beat accept of frame 1.
//     -> next cycle m_data=C691 and cnt=2; drop_count=0.
//  5) rst asserted at beat 20.
//     -> m_valid=0 immediately; frame_count=0.
//     Then a new frame after release -> header cnt=1 with correct checksum.
//  6) enable=0 with frame_valid pulses -> no output, no drops.
//     Preload frame_count to 32'hFFFFFFFF (force), then capture -> cnt wraps to 0.

Source files
------------

// File: rtl/rhd_frame_packer.sv
// rhd_frame_packer
//   Captures a completed CHANNELS x SAMPLE_W scan frame into a shadow register and
//   serialises it as a framed word stream:
//     MAGIC, cnt[31:16], cnt[15:0], ch0 .. ch(CHANNELS-1), checksum
//   where cnt is the post-increment frame counter and checksum is the XOR of every
//   preceding word of the frame. Frames arriving while a frame drains are dropped
//   and counted.
//
// Stream handshake: a beat transfers on a rising edge where m_valid & m_ready.
//   Once m_valid is high, m_data/m_valid/m_last hold until that beat transfers;
//   m_valid never falls inside a frame (only async reset can abandon one).
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   enable           1 = accept frames; 0 = ignore frame_valid entirely
//   frame_in         packed frame, channel i = frame_in[i*SAMPLE_W +: SAMPLE_W]
//   frame_valid      1-cycle pulse, frame_in complete this cycle
//   m_data/m_valid/m_last/m_ready   output word stream
//   busy             high whenever the packer is not idle
//   frame_count      frames captured since reset (wraps)
//   drop_count       frames dropped (saturating), overflow sticky drop flag
//   clear_overflow   clears overflow and drop_count
//   dbg_state        current FSM state encoding, for observation only
module rhd_frame_packer #(
    parameter int                  CHANNELS = 32,
    parameter int                  SAMPLE_W = 16,
    parameter logic [SAMPLE_W-1:0] MAGIC    = 16'hC691
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CHANNELS*SAMPLE_W-1:0] frame_in,
    input  logic                         frame_valid,
    output logic [SAMPLE_W-1:0]          m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last,
    output logic                         busy,
    output logic [31:0]                  frame_count,
    output logic [15:0]                  drop_count,
    output logic                         overflow,
    input  logic                         clear_overflow,
    output logic [2:0]                   dbg_state
);

    localparam int IDX_W = $clog2(CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CNTH = 3'd2,
        S_CNTL = 3'd3,
        S_SMP  = 3'd4,
        S_CSUM = 3'd5
    } state_t;

    state_t                       state_q;
    logic [CHANNELS*SAMPLE_W-1:0] shadow_q;
    logic [31:0]                  frame_count_q;
    logic [31:0]                  cnt_q;
    logic [SAMPLE_W-1:0]          xor_q;
    logic [IDX_W-1:0]             idx_q;
    logic [SAMPLE_W-1:0]          m_data_q;
    logic                         m_valid_q;
    logic                         m_last_q;
    logic [15:0]                  drop_count_q;
    logic                         overflow_q;

    logic                accept;
    logic                final_beat;
    logic                fv_en;
    logic                capture;
    logic                drop;
    logic [31:0]         frame_count_d;
    logic [SAMPLE_W-1:0] xor_d;
    logic [IDX_W-1:0]    idx_d;
    logic [SAMPLE_W-1:0] sample_d;

    assign accept        = m_valid_q & m_ready;
    assign final_beat    = (state_q == S_CSUM) & accept;
    assign fv_en         = frame_valid & enable;
    // A frame landing on the checksum accept is taken directly: no idle gap, no drop.
    assign capture       = fv_en & ((state_q == S_IDLE) | final_beat);
    assign drop          = fv_en & (state_q != S_IDLE) & ~final_beat;
    assign frame_count_d = frame_count_q + 32'd1;
    assign xor_d         = xor_q ^ m_data_q;
    // Index of the next sample to present: 0 when leaving CNTL, idx+1 inside SMP.
    assign idx_d         = (state_q == S_SMP) ? idx_q + 1'b1 : '0;
    assign sample_d      = shadow_q[idx_d*SAMPLE_W +: SAMPLE_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            frame_count_q <= '0;
            cnt_q         <= '0;
            xor_q         <= '0;
            idx_q         <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (capture) begin
                shadow_q      <= frame_in;
                frame_count_q <= frame_count_d;
                cnt_q         <= frame_count_d;
                xor_q         <= '0;
                idx_q         <= '0;
                m_data_q      <= MAGIC;
                m_valid_q     <= 1'b1;
                m_last_q      <= 1'b0;
                state_q       <= S_HDR;
            end else if (accept) begin
                case (state_q)
                    S_HDR: begin
                        xor_q    <= xor_d;
                        m_data_q <= cnt_q[31:16];
                        state_q  <= S_CNTH;
                    end
                    S_CNTH: begin
                        xor_q    <= xor_d;
                        m_data_q <= cnt_q[15:0];
                        state_q  <= S_CNTL;
                    end
                    S_CNTL: begin
                        xor_q    <= xor_d;
                        idx_q    <= idx_d;
                        m_data_q <= sample_d;
                        state_q  <= S_SMP;
                    end
                    S_SMP: begin
                        xor_q <= xor_d;
                        if (idx_q == LAST_IDX) begin
                            // Checksum folds in the last sample being accepted now.
                            m_data_q <= xor_d;
                            m_last_q <= 1'b1;
                            state_q  <= S_CSUM;
                        end else begin
                            idx_q    <= idx_d;
                            m_data_q <= sample_d;
                        end
                    end
                    S_CSUM: begin
                        m_data_q  <= '0;
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    default: begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                endcase
            end

            // A drop coinciding with clear restarts the count at one.
            if (drop) begin
                overflow_q <= 1'b1;
                if (clear_overflow) begin
                    drop_count_q <= 16'd1;
                end else if (drop_count_q != 16'hFFFF) begin
                    drop_count_q <= drop_count_q + 16'd1;
                end
            end else if (clear_overflow) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign busy        = (state_q != S_IDLE);
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rhd_frame_packer.sv
module tb_rhd_frame_packer;

    localparam int CH = 32;
    localparam int SW = 16;
    localparam int FW = CH * SW;
    localparam logic [15:0] MAGIC = 16'hC691;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [FW-1:0] frame_in;
    logic          frame_valid;
    logic [SW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic [31:0]   frame_count;
    logic [15:0]   drop_count;
    logic          overflow;
    logic          clear_overflow;
    logic [2:0]    dbg_state;

    rhd_frame_packer dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .frame_in       (frame_in),
        .frame_valid    (frame_valid),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_last         (m_last),
        .busy           (busy),
        .frame_count    (frame_count),
        .drop_count     (drop_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [SW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [SW-1:0] got_q[$];
    logic          got_last_q[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            stall_err = 0;
    logic [31:0]   model_cnt = 0;
    bit            ready_rand = 0;

    // ---------------- sink: ready driver ----------------
    always @(posedge clk) begin
        #1;
        m_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end

    // ---------------- monitor: record accepted beats, watch stalls ----------------
    logic          prev_stall = 1'b0;
    logic [SW-1:0] prev_data;
    logic          prev_last;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
                stall_err++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last_q.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_frame(input logic [FW-1:0] fin, input logic [31:0] cnt);
        logic [15:0] w[36];
        logic [15:0] x;
        w[0] = MAGIC;
        w[1] = cnt[31:16];
        w[2] = cnt[15:0];
        for (int i = 0; i < CH; i++) w[3+i] = fin[i*SW +: SW];
        x = '0;
        for (int i = 0; i < 35; i++) x = x ^ w[i];
        w[35] = x;
        for (int i = 0; i < 36; i++) begin
            exp_q.push_back(w[i]);
            exp_last_q.push_back(i == 35);
        end
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] r;
        for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_test();
        exp_q.delete();
        exp_last_q.delete();
        got_q.delete();
        got_last_q.delete();
        stall_err = 0;
    endtask

    task automatic pulse_frame(input logic [FW-1:0] fin);
        frame_in    = fin;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        frame_in    = rand_frame();  // upstream moves on immediately
    endtask

    task automatic wait_beats(input int n, input string name);
        int t;
        t = 0;
        while (got_q.size() < n && t < 3000) begin
            tick();
            t++;
        end
        if (got_q.size() < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d beats, need %0d", name, got_q.size(), n);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({m_valid, m_last, busy, overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b exp 0000", {m_valid, m_last, busy, overflow});
        end
        n_cmp++;
        if (m_data !== 16'h0 || frame_count !== 32'h0 || drop_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values: got data=%h cnt=%h drop=%h exp 0", m_data, frame_count, drop_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [FW-1:0] fin;
        start_test();
        for (int i = 0; i < CH; i++) fin[i*SW +: SW] = 16'h0100 + 16'(i);
        pulse_frame(fin);
        model_cnt++;
        push_frame(fin, model_cnt);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== MAGIC || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_latency: got v=%b d=%h busy=%b exp 1 %h 1", m_valid, m_data, busy, MAGIC);
        end
        n_cmp++;
        if (frame_count !== model_cnt) begin
            n_fail++;
            $display("FAIL t1_frame_count: got %h exp %h", frame_count, model_cnt);
        end
        for (int k = 0; k < 35; k++) tick();
        n_cmp++;
        if (busy !== 1'b1 || m_last !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_last_beat: got busy=%b last=%b exp 1 1", busy, m_last);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_busy_drop: got busy=%b valid=%b exp 0 0", busy, m_valid);
        end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL t1_len: got %0d exp %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t1_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] fin;
        start_test();
        ready_rand = 1'b1;
        fin = rand_frame();
        pulse_frame(fin);
        model_cnt++;
        push_frame(fin, model_cnt);
        wait_beats(36, "t2");
        for (int k = 0; k < 10; k++) tick();
        ready_rand = 1'b0;
        tick();
        n_cmp++;
        if (got_q.size() !== 36) begin
            n_fail++;
            $display("FAIL t2_beat_count: got %0d exp 36", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t2_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
        n_cmp++;
        if (stall_err !== 0) begin
            n_fail++;
            $display("FAIL t2_stall_stable: got %0d unstable stalls exp 0", stall_err);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t2_idle: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_drop();
        logic [FW-1:0] fa, fc;
        start_test();
        fa = rand_frame();
        pulse_frame(fa);
        model_cnt++;
        push_frame(fa, model_cnt);
        wait_beats(9, "t3a");
        pulse_frame(rand_frame());  // arrives at beat 10: dropped
        wait_beats(36, "t3b");
        tick();
        n_cmp++;
        if (drop_count !== 16'd1 || overflow !== 1'b1 || frame_count !== model_cnt) begin
            n_fail++;
            $display("FAIL t3_drop: got drop=%0d ovf=%b cnt=%h exp 1 1 %h", drop_count, overflow, frame_count, model_cnt);
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        n_cmp++;
        if (drop_count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_clear: got drop=%0d ovf=%b exp 0 0", drop_count, overflow);
        end
        // Two drops, then a drop coinciding with clear.
        fc = rand_frame();
        pulse_frame(fc);
        model_cnt++;
        push_frame(fc, model_cnt);
        wait_beats(39, "t3c");
        pulse_frame(rand_frame());
        wait_beats(42, "t3d");
        pulse_frame(rand_frame());
        n_cmp++;
        if (drop_count !== 16'd2) begin
            n_fail++;
            $display("FAIL t3_drop_accum: got %0d exp 2", drop_count);
        end
        wait_beats(45, "t3e");
        clear_overflow = 1'b1;
        pulse_frame(rand_frame());
        clear_overflow = 1'b0;
        n_cmp++;
        if (drop_count !== 16'd1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL t3_drop_vs_clear: got drop=%0d ovf=%b exp 1 1", drop_count, overflow);
        end
        wait_beats(72, "t3f");
        tick();
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t3_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
        n_cmp++;
        if (got_q.size() !== 72 || frame_count !== model_cnt) begin
            n_fail++;
            $display("FAIL t3_totals: got beats=%0d cnt=%h exp 72 %h", got_q.size(), frame_count, model_cnt);
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] fa, fb;
        int t;
        start_test();
        fa = rand_frame();
        fb = rand_frame();
        pulse_frame(fa);
        model_cnt++;
        push_frame(fa, model_cnt);
        t = 0;
        while (!(m_valid && m_last) && t < 100) begin
            tick();
            t++;
        end
        n_cmp++;
        if (!(m_valid && m_last)) begin
            n_fail++;
            $display("FAIL t4_find_last: got valid=%b last=%b exp 1 1", m_valid, m_last);
        end
        pulse_frame(fb);
        model_cnt++;
        push_frame(fb, model_cnt);
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== MAGIC || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_no_gap: got v=%b d=%h l=%b exp 1 %h 0", m_valid, m_data, m_last, MAGIC);
        end
        wait_beats(72, "t4");
        tick();
        n_cmp++;
        if (drop_count !== 16'd0 || frame_count !== model_cnt || got_q.size() !== 72) begin
            n_fail++;
            $display("FAIL t4_counts: got drop=%0d cnt=%h beats=%0d exp 0 %h 72", drop_count, frame_count, got_q.size(), model_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t4_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [FW-1:0] fin;
        start_test();
        pulse_frame(rand_frame());
        wait_beats(19, "t5a");
        rst = 1'b1;
        #1;
        n_cmp++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 32'h0) begin
            n_fail++;
            $display("FAIL t5_async_reset: got v=%b busy=%b cnt=%h exp 0 0 0", m_valid, busy, frame_count);
        end
        tick();
        rst = 1'b0;
        model_cnt = 0;
        tick();
        start_test();
        fin = rand_frame();
        pulse_frame(fin);
        model_cnt++;
        push_frame(fin, model_cnt);
        wait_beats(36, "t5b");
        tick();
        n_cmp++;
        if (got_q.size() !== 36 || frame_count !== 32'd1) begin
            n_fail++;
            $display("FAIL t5_restart: got beats=%0d cnt=%h exp 36 1", got_q.size(), frame_count);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t5_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
    endtask

    task automatic test_enable_and_wrap();
        logic [FW-1:0] fa, fb;
        start_test();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pulse_frame(rand_frame());
            for (int j = 0; j < $urandom_range(1, 5); j++) tick();
        end
        for (int k = 0; k < 20; k++) tick();
        n_cmp++;
        if (got_q.size() !== 0 || busy !== 1'b0 || drop_count !== 16'd0 || frame_count !== model_cnt) begin
            n_fail++;
            $display("FAIL t6_disabled: got beats=%0d busy=%b drop=%0d cnt=%h exp 0 0 0 %h", got_q.size(), busy, drop_count, frame_count, model_cnt);
        end
        // Disable mid-frame: the frame finishes, pulses are neither taken nor dropped.
        enable = 1'b1;
        fa = rand_frame();
        pulse_frame(fa);
        model_cnt++;
        push_frame(fa, model_cnt);
        wait_beats(5, "t6a");
        enable = 1'b0;
        pulse_frame(rand_frame());
        tick();
        pulse_frame(rand_frame());
        wait_beats(36, "t6b");
        tick();
        n_cmp++;
        if (drop_count !== 16'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_enable_mid: got drop=%0d ovf=%b busy=%b exp 0 0 0", drop_count, overflow, busy);
        end
        enable = 1'b1;
        // Counter wrap.
        force dut.frame_count_q = 32'hFFFF_FFFF;
        tick();
        release dut.frame_count_q;
        model_cnt = 32'hFFFF_FFFF;
        tick();
        fb = rand_frame();
        pulse_frame(fb);
        model_cnt++;
        push_frame(fb, model_cnt);
        n_cmp++;
        if (frame_count !== 32'h0) begin
            n_fail++;
            $display("FAIL t6_wrap: got %h exp 00000000", frame_count);
        end
        wait_beats(72, "t6c");
        tick();
        n_cmp++;
        if (got_q.size() !== 72) begin
            n_fail++;
            $display("FAIL t6_len: got %0d exp 72", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i] || got_last_q[i] !== exp_last_q[i]) begin
                n_fail++;
                $display("FAIL t6_word%0d: got %h/%b exp %h/%b", i, got_q[i], got_last_q[i], exp_q[i], exp_last_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst            = 1'b1;
        enable         = 1'b1;
        frame_in       = '0;
        frame_valid    = 1'b0;
        m_ready        = 1'b1;
        clear_overflow = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_drop();
        test_back_to_back();
        test_mid_reset();
        test_enable_and_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
